// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined valid/ready bitwise logic unit; optional zero/ones flags under LOGIC_UNIT_FLAGS_EN
module logic_unit_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic             out_zero,
    output logic             out_ones,
`endif
    output logic             busy
);
`ifdef LOGIC_UNIT_FLAGS_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH;
`endif
    logic [WIDTH-1:0] w_res;
    logic [DW-1:0]    w_in;
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_uv;
    logic [DW-1:0]    r_d  [DEPTH];
    logic [DW-1:0]    w_ud [DEPTH];

    // bitwise operation on the incoming operands
    always_comb begin
        case (op)
            3'b000:  w_res = a & b;
            3'b001:  w_res = a | b;
            3'b010:  w_res = a ^ b;
            3'b011:  w_res = ~(a | b);
            3'b100:  w_res = a & ~b;
            3'b101:  w_res = a | ~b;
            3'b110:  w_res = ~(a ^ b);
            default: w_res = a;
        endcase
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    assign w_in     = {w_res == '0, &w_res, w_res};
    assign out_zero = r_d[DEPTH-1][WIDTH+1];
    assign out_ones = r_d[DEPTH-1][WIDTH];
`else
    assign w_in = w_res;
`endif

    // a stage advances when it or any stage downstream of it is empty, or the consumer pops
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        assign w_adv[k] = out_ready || !(&r_v[DEPTH-1:k]);
        if (k == 0) begin : g_first
            assign w_uv[k] = in_valid;
            assign w_ud[k] = w_in;
        end else begin : g_next
            assign w_uv[k] = r_v[k-1];
            assign w_ud[k] = r_d[k-1];
        end
    end

    // stage registers: valid follows upstream on advance, data loads only with a valid upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_uv[k];
                    if (w_uv[k]) r_d[k] <= w_ud[k];
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[DEPTH-1];
    assign result    = r_d[DEPTH-1][WIDTH-1:0];
    assign busy      = |r_v;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and scoreboard checks of logic_unit_pipe at DEPTH=2/WIDTH=64 and DEPTH=4/WIDTH=128
module tb_logic_unit_pipe;
    logic clk, rst_n;
    logic iv2, ir2, ov2, or2, busy2;
    logic [2:0] op2;
    logic [63:0] a2, b2, res2;
    logic iv4, ir4, ov4, or4, busy4;
    logic [2:0] op4;
    logic [127:0] a4, b4, res4;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic z2, o2, z4, o4;
`endif

    logic_unit_pipe #(.WIDTH(64), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .result(res2),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero(z2), .out_ones(o2),
`endif
        .busy(busy2));

    logic_unit_pipe #(.WIDTH(128), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .result(res4),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero(z4), .out_ones(o4),
`endif
        .busy(busy4));

    typedef struct {logic [127:0] d; int c;} ent_t;
    ent_t q2[$];
    ent_t q4[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit lat2_on = 0;
    bit lat4_on = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] gold(input logic [2:0] o, input logic [127:0] x, input logic [127:0] y, input int w);
        logic [127:0] r;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x | y);
            3'd4: r = x & ~y;
            3'd5: r = x | ~y;
            3'd6: r = ~(x ^ y);
            default: r = x;
        endcase
        return r & ((128'd1 << w) - 128'd1);
    endfunction

    // score any pop/accept happening at the coming edge, then advance to the next negedge
    task automatic tick();
        ent_t e;
        if (ov2 && or2) begin
            if (q2.size() == 0) chk("sb2_extra", 128'(ov2), 128'd0);
            else begin
                e = q2.pop_front();
                chk("sb2", 128'(res2), e.d);
                if (lat2_on) chk("lat2", 128'(cyc - e.c), 128'd2);
            end
        end
        if (ov4 && or4) begin
            if (q4.size() == 0) chk("sb4_extra", 128'(ov4), 128'd0);
            else begin
                e = q4.pop_front();
                chk("sb4", res4, e.d);
                if (lat4_on) chk("lat4", 128'(cyc - e.c), 128'd4);
            end
        end
        if (iv2 && ir2) q2.push_back('{gold(op2, {64'd0, a2}, {64'd0, b2}, 64), cyc});
        if (iv4 && ir4) q4.push_back('{gold(op4, a4, b4, 128), cyc});
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        rst_n = 0;
        iv2 = 0; or2 = 1; op2 = 0; a2 = 0; b2 = 0;
        iv4 = 0; or4 = 1; op4 = 0; a4 = 0; b4 = 0;
        #12;
        chk("rst_ov", 128'(ov2), 128'd0);
        chk("rst_res", 128'(res2), 128'd0);
        chk("rst_busy", 128'(busy2), 128'd0);
        chk("rst_ir", 128'(ir2), 128'd1);
        chk("rst_ir4", 128'(ir4), 128'd1);
        @(negedge clk);
        rst_n = 1;

        // hand-computed vectors, then the low-byte sweep, one accept per cycle
        lat2_on = 1;
        iv2 = 1; op2 = 3'b001; a2 = 64'h0F; b2 = 64'hF0;
        tick();
        op2 = 3'b011;
        tick();
        iv2 = 0;
        chk("or_ov", 128'(ov2), 128'd1);
        chk("or_0f_f0", 128'(res2), 128'h00FF);
        tick();
        chk("nor_0f_f0", 128'(res2), 128'hFFFF_FFFF_FFFF_FF00);
        tick();
        iv2 = 1;
        for (int o = 0; o < 8; o++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    op2 = 3'(o); a2 = 64'(i * 17); b2 = 64'(j * 17);
                    tick();
                end
        iv2 = 0;
        repeat (4) tick();
        chk("sweep_drained", 128'(q2.size()), 128'd0);
        lat2_on = 0;

`ifdef LOGIC_UNIT_FLAGS_EN
        iv2 = 1; op2 = 3'b000; a2 = {16{4'hA}}; b2 = {16{4'h5}};
        tick();
        iv2 = 0;
        tick();
        chk("flag_and_res", 128'(res2), 128'd0);
        chk("flag_zero", 128'(z2), 128'd1);
        chk("flag_zero_ones", 128'(o2), 128'd0);
        tick();
        iv2 = 1; op2 = 3'b110; a2 = 64'h1234_5678; b2 = 64'h1234_5678;
        tick();
        iv2 = 0;
        tick();
        chk("flag_ones", 128'(o2), 128'd1);
        chk("flag_ones_zero", 128'(z2), 128'd0);
        tick();
`endif

        // backpressure: two accepts fill DEPTH=2, third waits
        or2 = 0; iv2 = 1; op2 = 3'b111; b2 = 0;
        a2 = 64'hD1; #1;
        chk("bp_rdy1", 128'(ir2), 128'd1);
        tick();
        a2 = 64'hD2;
        chk("bp_rdy2", 128'(ir2), 128'd1);
        tick();
        a2 = 64'hD3;
        chk("bp_full", 128'(ir2), 128'd0);
        chk("bp_ov", 128'(ov2), 128'd1);
        chk("bp_hold1", 128'(res2), 128'hD1);
        tick();
        chk("bp_hold2", 128'(res2), 128'hD1);
        chk("bp_full2", 128'(ir2), 128'd0);
        or2 = 1; #1;
        chk("bp_ready_ret", 128'(ir2), 128'd1);
        tick();
        iv2 = 0;
        chk("bp_second", 128'(res2), 128'hD2);
        tick();
        chk("bp_third", 128'(res2), 128'hD3);
        tick();
        chk("bp_empty", 128'(ov2), 128'd0);
        chk("bp_busy", 128'(busy2), 128'd0);

        // bubble collapse at DEPTH=4 under a stalled consumer
        or4 = 0; #1;
        iv4 = 1; op4 = 3'b111; b4 = 0; a4 = 128'hA1;
        tick();
        iv4 = 0;
        tick();
        tick();
        iv4 = 1; a4 = 128'hA2;
        chk("bub_rdy", 128'(ir4), 128'd1);
        tick();
        iv4 = 0;
        tick();
        tick();
        chk("bub_ov", 128'(ov4), 128'd1);
        chk("bub_res", res4, 128'hA1);
        chk("bub_busy", 128'(busy4), 128'd1);
        chk("bub_rdy2", 128'(ir4), 128'd1);
        iv4 = 1; a4 = 128'hA3;
        tick();
        a4 = 128'hA4;
        chk("bub_rdy3", 128'(ir4), 128'd1);
        tick();
        iv4 = 0;
        chk("bub_full", 128'(ir4), 128'd0);
        or4 = 1;
        repeat (6) tick();
        chk("bub_drained", 128'(q4.size()), 128'd0);

        // async reset with two transactions in flight
        or2 = 0; iv2 = 1; op2 = 3'b010; a2 = 64'hFF00; b2 = 64'h0FF0;
        tick();
        a2 = 64'h1111;
        tick();
        iv2 = 0;
        #2 rst_n = 0;
        #1;
        chk("ar_ov", 128'(ov2), 128'd0);
        chk("ar_res", 128'(res2), 128'd0);
        chk("ar_busy", 128'(busy2), 128'd0);
        chk("ar_ir", 128'(ir2), 128'd1);
        #1 rst_n = 1;
        q2.delete();
        q4.delete();
        or2 = 1;
        @(negedge clk);
        cyc++;
        repeat (3) begin
            chk("ar_no_stale", 128'(ov2), 128'd0);
            tick();
        end

        // back-to-back at DEPTH=4 with latency check, then random ops and backpressure
        lat4_on = 1;
        iv4 = 1;
        for (int i = 0; i < 20; i++) begin
            op4 = 3'($urandom_range(0, 7));
            a4 = {$urandom, $urandom, $urandom, $urandom};
            b4 = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        iv4 = 0;
        repeat (6) tick();
        lat4_on = 0;
        for (int i = 0; i < 400; i++) begin
            iv4 = 1'($urandom_range(0, 1));
            or4 = ($urandom_range(0, 3) != 0);
            op4 = 3'($urandom_range(0, 7));
            a4 = {$urandom, $urandom, $urandom, $urandom};
            b4 = {$urandom, $urandom, $urandom, $urandom};
            #1;
            tick();
        end
        iv4 = 0; or4 = 1;
        repeat (8) tick();
        chk("rnd_drained", 128'(q4.size()), 128'd0);
        chk("rnd_busy", 128'(busy4), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
